// File: rtl/fd_pipe_reg.sv
// Fetch PC select, F predicted-PC register and F->D pipeline register for the Y86-64 pipeline.
// Optional build macro FD_PERF_CNT_EN adds saturating stall/bubble counters on D.
module fd_pipe_reg #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [3:0]  f_rA,
    input  logic [3:0]  f_rB,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic [2:0]  f_stat,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    output logic [63:0] f_pc,
    output logic [63:0] F_predPC,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP,
    output logic [2:0]  D_stat
`ifdef FD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    localparam int unsigned WORD_W = 64;
    localparam int unsigned CNT_W  = 32;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [2:0] STAT_AOK = 3'd1;

    logic [WORD_W-1:0] pred_pc;

    // Fetch address: mispredicted jXX recovery beats ret target beats prediction.
    always_comb begin
        f_pc = F_predPC;
        if (M_icode == I_JXX && !M_Cnd) begin
            f_pc = M_valA;
        end else if (W_icode == I_RET) begin
            f_pc = W_valM;
        end
    end

    // Jumps are predicted taken and calls go to their target.
    always_comb begin
        pred_pc = f_valP;
        if (f_icode == I_JXX || f_icode == I_CALL) begin
            pred_pc = f_valC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            F_predPC <= RESET_PC;
        end else if (!F_stall) begin
            F_predPC <= pred_pc;
        end
    end

    // Bubble overrides stall so the hazard unit can squash a held instruction.
    always_ff @(posedge clk) begin
        if (rst || D_bubble) begin
            D_icode <= I_NOP;
            D_ifun  <= 4'h0;
            D_rA    <= REG_NONE;
            D_rB    <= REG_NONE;
            D_valC  <= '0;
            D_valP  <= '0;
            D_stat  <= STAT_AOK;
        end else if (!D_stall) begin
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_rA;
            D_rB    <= f_rB;
            D_valC  <= f_valC;
            D_valP  <= f_valP;
            D_stat  <= f_stat;
        end
    end

`ifdef FD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (D_bubble && bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            if (D_stall && !D_bubble && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Bench for fd_pipe_reg: directed scenarios plus randomized traffic against a behavioural model.
// Honours FD_PERF_CNT_EN when defined at compile time.
module tb_fd_pipe_reg;

    localparam logic [63:0] RPC = 64'h100;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [2:0]  stat;
    } dreg_t;

    localparam dreg_t NOP_D = '{icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF,
                                valc: 64'd0, valp: 64'd0, stat: 3'd1};

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic [2:0]  f_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic        F_stall, D_stall, D_bubble;
    logic [63:0] f_pc, F_predPC;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [2:0]  D_stat;
`ifdef FD_PERF_CNT_EN
    logic [31:0] stall_cnt, bubble_cnt;
    longint      m_stall_cnt, m_bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [63:0] m_pred;
    dreg_t       m_d;
    dreg_t       dut_d;

    always #5 clk = ~clk;

    assign dut_d = '{icode: D_icode, ifun: D_ifun, ra: D_rA, rb: D_rB,
                     valc: D_valC, valp: D_valP, stat: D_stat};

    fd_pipe_reg #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP), .f_stat(f_stat),
        .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .f_pc(f_pc), .F_predPC(F_predPC),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat)
`ifdef FD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    // Reference fetch-address choice from the current stage contents.
    function automatic logic [63:0] model_fpc();
        if (M_icode == 4'h7 && M_Cnd == 1'b0) return M_valA;
        if (W_icode == 4'h9) return W_valM;
        return m_pred;
    endfunction

    // Advance one clock: model next state from the inputs present at the edge.
    task automatic step();
        logic [63:0] n_pred;
        dreg_t       n_d;
        n_pred = m_pred;
        n_d    = m_d;
        if (rst) begin
            n_pred = RPC;
            n_d    = NOP_D;
        end else begin
            if (!F_stall) n_pred = (f_icode == 4'h7 || f_icode == 4'h8) ? f_valC : f_valP;
            if (D_bubble) n_d = NOP_D;
            else if (!D_stall) n_d = '{f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat};
        end
`ifdef FD_PERF_CNT_EN
        if (rst) begin
            m_stall_cnt = 0;
            m_bubble_cnt = 0;
        end else if (D_bubble) begin
            if (m_bubble_cnt < 64'hFFFF_FFFF) m_bubble_cnt++;
        end else if (D_stall) begin
            if (m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
        end
`endif
        @(posedge clk);
        #1;
        m_pred = n_pred;
        m_d    = n_d;
    endtask

    task automatic set_fetch(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                             input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
        f_icode = ic; f_ifun = ifn; f_rA = ra; f_rB = rb;
        f_valC = vc; f_valP = vp; f_stat = 3'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (F_predPC !== 64'h100) begin
            bad++; $display("FAIL reset_predpc got=%h exp=%h", F_predPC, 64'h100);
        end
        total++;
        if (f_pc !== 64'h100) begin
            bad++; $display("FAIL reset_fpc got=%h exp=%h", f_pc, 64'h100);
        end
        total++;
        if (D_icode !== 4'h1 || D_rA !== 4'hF || D_rB !== 4'hF || D_stat !== 3'd1 ||
            D_ifun !== 4'h0 || D_valC !== 64'd0 || D_valP !== 64'd0) begin
            bad++; $display("FAIL reset_dreg got=%h exp=%h", dut_d, NOP_D);
        end
    endtask

    task automatic test_irmovq();
        set_fetch(4'h3, 4'h0, 4'hF, 4'h2, 64'h40, 64'h10A);
        step();
        total++;
        if (F_predPC !== 64'h10A) begin
            bad++; $display("FAIL irmovq_predpc got=%h exp=%h", F_predPC, 64'h10A);
        end
        total++;
        if (D_icode !== 4'h3 || D_rB !== 4'h2 || D_valC !== 64'h40 || D_valP !== 64'h10A) begin
            bad++; $display("FAIL irmovq_dreg got=%h exp=%h", dut_d, m_d);
        end
    endtask

    task automatic test_mispredict();
        set_fetch(4'h7, 4'h1, 4'hF, 4'hF, 64'h200, 64'h109);
        step();
        total++;
        if (F_predPC !== 64'h200) begin
            bad++; $display("FAIL jxx_predpc got=%h exp=%h", F_predPC, 64'h200);
        end
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h109;
        #1;
        total++;
        if (f_pc !== 64'h109) begin
            bad++; $display("FAIL mispredict_fpc got=%h exp=%h", f_pc, 64'h109);
        end
        M_Cnd = 1'b1;
        #1;
        total++;
        if (f_pc !== 64'h200) begin
            bad++; $display("FAIL taken_fpc got=%h exp=%h", f_pc, 64'h200);
        end
        M_icode = 4'h0; M_Cnd = 1'b0;
    endtask

    task automatic test_ret_select();
        W_icode = 4'h9; W_valM = 64'h3C0; M_icode = 4'h1;
        #1;
        total++;
        if (f_pc !== 64'h3C0) begin
            bad++; $display("FAIL ret_fpc got=%h exp=%h", f_pc, 64'h3C0);
        end
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h50;
        #1;
        total++;
        if (f_pc !== 64'h50) begin
            bad++; $display("FAIL ret_vs_mispredict_fpc got=%h exp=%h", f_pc, 64'h50);
        end
        M_icode = 4'h0; W_icode = 4'h0;
    endtask

    task automatic test_stall();
        logic [63:0] hold_pc;
        dreg_t       hold_d;
        hold_pc = F_predPC;
        hold_d  = m_d;
        F_stall = 1'b1; D_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_fetch(4'h6, 4'(i), 4'h3, 4'h4, 64'h1000 + 64'(i), 64'h2000 + 64'(i));
            step();
            total++;
            if (F_predPC !== hold_pc || dut_d !== hold_d) begin
                bad++; $display("FAIL stall_hold%0d got=%h/%h exp=%h/%h", i, F_predPC, dut_d, hold_pc, hold_d);
            end
        end
        F_stall = 1'b0; D_stall = 1'b0;
        step();
        total++;
        if (F_predPC !== 64'h2001 || D_ifun !== 4'h1 || D_valC !== 64'h1001) begin
            bad++; $display("FAIL stall_release got=%h/%h exp=%h/%h", F_predPC, dut_d, 64'h2001, m_d);
        end
    endtask

    task automatic test_bubble();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_fetch(4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h300);
        step();
        D_bubble = 1'b1; D_stall = 1'b1;
        step();
        D_bubble = 1'b0; D_stall = 1'b0;
        total++;
        if (dut_d !== NOP_D) begin
            bad++; $display("FAIL bubble_dreg got=%h exp=%h", dut_d, NOP_D);
        end
`ifdef FD_PERF_CNT_EN
        total++;
        if (bubble_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
            bad++; $display("FAIL bubble_counts got=%0d/%0d exp=1/0", bubble_cnt, stall_cnt);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 29) == 0);
            F_stall  = ($urandom_range(0, 3) == 0);
            D_stall  = ($urandom_range(0, 3) == 0);
            D_bubble = ($urandom_range(0, 4) == 0);
            set_fetch(4'($urandom_range(0, 11)), 4'($urandom), 4'($urandom), 4'($urandom),
                      {$urandom, $urandom}, {$urandom, $urandom});
            f_stat  = 3'($urandom_range(1, 4));
            M_icode = ($urandom_range(0, 2) == 0) ? 4'h7 : 4'($urandom);
            M_Cnd   = 1'($urandom);
            M_valA  = {$urandom, $urandom};
            W_icode = ($urandom_range(0, 2) == 0) ? 4'h9 : 4'($urandom);
            W_valM  = {$urandom, $urandom};
            #1;
            total++;
            if (f_pc !== model_fpc()) begin
                bad++; $display("FAIL rand_fpc[%0d] got=%h exp=%h", i, f_pc, model_fpc());
            end
            step();
            total++;
            if (F_predPC !== m_pred || dut_d !== m_d) begin
                bad++; $display("FAIL rand_state[%0d] got=%h/%h exp=%h/%h", i, F_predPC, dut_d, m_pred, m_d);
            end
`ifdef FD_PERF_CNT_EN
            total++;
            if (stall_cnt !== 32'(m_stall_cnt) || bubble_cnt !== 32'(m_bubble_cnt)) begin
                bad++; $display("FAIL rand_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, stall_cnt, bubble_cnt, m_stall_cnt, m_bubble_cnt);
            end
`endif
        end
        rst = 1'b0; F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        set_fetch(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
        M_icode = 4'h0; M_Cnd = 1'b0; M_valA = 64'd0;
        W_icode = 4'h0; W_valM = 64'd0;
        F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
        m_pred = 64'd0;
        m_d = NOP_D;
`ifdef FD_PERF_CNT_EN
        m_stall_cnt = 0;
        m_bubble_cnt = 0;
`endif
        @(negedge clk);
        test_reset();
        test_irmovq();
        test_mispredict();
        test_ret_select();
        test_stall();
        test_bubble();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fd_pipe_reg.md
Name:
fd_pipe_reg

Overview:
PC-select, fetch register (F) and fetch-to-decode pipeline register (D) for the pipelined Y86-64 core; drops in between the existing fetch logic and decode. Picks the fetch PC from the predicted PC, a mispredicted-branch recovery or a ret target, predicts the next PC, and latches fetch results into D under hazard-unit stall/bubble control.

Parameters:
RESET_PC, 64'd0, value loaded into F_predPC on reset (first fetch address).

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
f_icode  in  4  fetched instruction code
f_ifun  in  4  fetched function code
f_rA  in  4  fetched rA (4'hF = none)
f_rB  in  4  fetched rB (4'hF = none)
f_valC  in  64  fetched constant word
f_valP  in  64  address of next sequential instruction
f_stat  in  3  fetch status (1 AOK, 2 HLT, 3 ADR, 4 INS)
M_icode  in  4  icode in memory stage
M_Cnd  in  1  branch condition of the memory-stage jXX
M_valA  in  64  fall-through address carried by the memory-stage jXX
W_icode  in  4  icode in write-back stage
W_valM  in  64  value popped by the write-back-stage ret
F_stall  in  1  hold F_predPC
D_stall  in  1  hold D register
D_bubble  in  1  load nop bubble into D
f_pc  out  64  selected fetch address (combinational)
F_predPC  out  64  registered predicted PC
D_icode  out  4  registered icode
D_ifun  out  4  registered ifun
D_rA  out  4  registered rA
D_rB  out  4  registered rB
D_valC  out  64  registered valC
D_valP  out  64  registered valP
D_stat  out  3  registered status

Behaviour:
- f_pc, combinational, priority order: M_icode==4'h7 && !M_Cnd -> M_valA; else W_icode==4'h9 -> W_valM; else F_predPC.
- Next prediction: f_icode 4'h7 (jXX) or 4'h8 (call) -> f_valC; all others -> f_valP.
- F register: rst -> RESET_PC; else F_stall -> hold; else load prediction. Fixed one-cycle latency.
- D register priority: rst > D_bubble > D_stall > load. Load captures all f_* inputs on the same edge (one-cycle latency).
- Bubble value, also the reset value: icode 4'h1 (nop), ifun 0, rA 4'hF, rB 4'hF, valC 0, valP 0, stat 3'd1 (AOK).
- D_bubble and D_stall asserted together: bubble wins. F_stall is independent of the D controls.
- rst mid-stream discards all in-flight state. f_pc equals RESET_PC on the first cycle after the reset edge, provided M_icode and W_icode are not 7 or 9.
- No arithmetic is performed. All values pass through unmodified at 64 bits, with no wrap handling.

Optional Feature:
FD_PERF_CNT_EN: when defined, adds outputs stall_cnt[31:0] and bubble_cnt[31:0].
- stall_cnt increments on every edge with D_stall=1 and D_bubble=0.
- bubble_cnt increments on every edge with D_bubble=1.
- Both counters saturate at 32'hFFFFFFFF and clear on rst.
When undefined, neither the ports nor the counters exist, and the remaining behaviour is identical.

Test Plan:
- rst=1 one cycle, RESET_PC=0x100 -> F_predPC=0x100, f_pc=0x100, D_icode=1, D_rA=D_rB=F, D_stat=1.
- Fetch irmovq (icode 3, rB=2, valC=0x40, valP=0x10A) -> next edge F_predPC=0x10A, D_icode=3, D_rB=2, D_valC=0x40, D_valP=0x10A.
- Fetch jXX (valC=0x200, valP=0x109), then M_icode=7, M_Cnd=0, M_valA=0x109 -> F_predPC=0x200 and f_pc=0x109 on the mispredict cycle.
- W_icode=9, W_valM=0x3C0 with M_icode=1 -> f_pc=0x3C0. Then also M_icode=7, M_Cnd=0, M_valA=0x50 -> f_pc=0x50.
- F_stall=1, D_stall=1 for 2 cycles with changing f_* -> F_predPC and all D_* unchanged. Release -> new values load next edge.
- D_bubble=1 together with D_stall=1 -> D becomes nop bubble. With FD_PERF_CNT_EN: bubble_cnt=1, stall_cnt=0.
